// File: rtl/oqpsk_pkg.sv
// rtl/oqpsk_pkg.sv - shared types, amplitude codes and cosine table generator for the OQPSK modulator
package oqpsk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef logic signed [1:0] amp_t;

   localparam amp_t AMP_ZERO = 2'sb00;
   localparam amp_t AMP_POS  = 2'sb01;
   localparam amp_t AMP_NEG  = 2'sb11;

   // Fixed-point scale and pi used only while elaborating the cosine table
   localparam longint FX_ONE = 64'sd1 <<< 28;
   localparam longint FX_PI  = 64'sd843314857;

   // Symbol bit to rail amplitude: 1 -> +1, 0 -> -1
   function automatic amp_t bit_to_amp(input logic b);
      return b ? AMP_POS : AMP_NEG;
   endfunction

   // round(A*cos(2*pi*k/n)) with A = 2^(r-1)-1, evaluated with integer Taylor series
   // on the first-quadrant angle so no real arithmetic is needed at elaboration
   function automatic int cos_val(input int k, input int n, input int r);
      longint amp;
      longint theta;
      longint x2;
      longint c_sum;
      longint s_sum;
      longint c_term;
      longint s_term;
      longint v;
      int     quad;
      int     m;
      amp    = (64'sd1 <<< (r - 1)) - 64'sd1;
      quad   = (k % n) / (n / 4);
      m      = (k % n) % (n / 4);
      theta  = (64'sd2 * FX_PI * longint'(m)) / longint'(n);
      x2     = (theta * theta) / FX_ONE;
      c_term = FX_ONE;
      c_sum  = FX_ONE;
      s_term = theta;
      s_sum  = theta;
      for (int i = 1; i <= 8; i++) begin
         c_term = -((c_term * x2) / FX_ONE) / longint'((2 * i - 1) * (2 * i));
         s_term = -((s_term * x2) / FX_ONE) / longint'((2 * i) * (2 * i + 1));
         c_sum  = c_sum + c_term;
         s_sum  = s_sum + s_term;
      end
      case (quad)
         0:       v = c_sum;
         1:       v = -s_sum;
         2:       v = -c_sum;
         default: v = s_sum;
      endcase
      if (v >= 0) begin
         return int'((amp * v + FX_ONE / 2) / FX_ONE);
      end
      return -int'((amp * (-v) + FX_ONE / 2) / FX_ONE);
   endfunction

endpackage

// File: rtl/oqpsk_cos_lut.sv
// rtl/oqpsk_cos_lut.sv - dual-read combinational cosine ROM for the I and Q rails
module oqpsk_cos_lut #(
   parameter int R  = 7,
   parameter int N  = 16,
   parameter int PW = $clog2(N)
) (
   input  logic [PW-1:0]       i_idx_i,
   input  logic [PW-1:0]       i_idx_q,
   output logic signed [R-1:0] o_cos_i,
   output logic signed [R-1:0] o_cos_q
);
   import oqpsk_pkg::*;

   logic signed [R-1:0] w_rom [N];

   for (genvar k = 0; k < N; k++) begin : g_rom
      localparam int COS_K = cos_val(k, N, R);
      assign w_rom[k] = COS_K[R-1:0];
   end

   assign o_cos_i = w_rom[i_idx_i];
   assign o_cos_q = w_rom[i_idx_q];

endmodule

// File: rtl/oqpsk_mod_stream.sv
// rtl/oqpsk_mod_stream.sv - streaming OQPSK modulator with symbol hold, underrun and Q-rail drain
module oqpsk_mod_stream #(
   parameter int R  = 7,
   parameter int N  = 16,
   parameter int F0 = 10
) (
   input  logic           C,
   input  logic           Reset,
   input  logic           sym_valid,
   input  logic [1:0]     sym_data,
   output logic           sym_ready,
   output logic [2*R-1:0] S,
   output logic           s_valid,
   output logic           underrun
);
   import oqpsk_pkg::*;

   localparam int SPS = N * F0;
   localparam int H   = SPS / 2;
   localparam int PW  = $clog2(N);
   localparam int CW  = $clog2(SPS);

   localparam logic [CW-1:0] CNT_H_END   = CW'(H - 1);
   localparam logic [CW-1:0] CNT_SYM_END = CW'(SPS - 1);
   localparam logic [PW-1:0] Q_OFFSET    = PW'(N / 4);

   if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_n
      $error("oqpsk_mod_stream: N must be a power of 2 and at least 4");
   end
   if ((SPS % 2) != 0) begin : g_bad_sps
      $error("oqpsk_mod_stream: samples per symbol must be even");
   end

   state_t              r_state;
   logic                r_hold_full;
   logic [1:0]          r_hold_data;
   logic [CW-1:0]       r_cnt;
   logic [PW-1:0]       r_phase;
   amp_t                r_amp_i;
   amp_t                r_amp_q;
   logic                r_q_pend;
   logic [2*R-1:0]      r_S;
   logic                r_s_valid;
   logic                r_underrun;

   state_t              w_state_nx;
   logic [CW-1:0]       w_cnt_nx;
   logic [PW-1:0]       w_phase_nx;
   amp_t                w_amp_i_nx;
   amp_t                w_amp_q_nx;
   logic                w_q_pend_nx;
   logic                w_load;
   logic                w_accept;
   logic                w_underrun_nx;
   logic [PW-1:0]       w_idx_q;
   logic signed [R-1:0] w_cos_i;
   logic signed [R-1:0] w_cos_q;
   logic signed [R-1:0] w_smp_i;
   logic signed [R-1:0] w_smp_q;

   assign sym_ready = ~r_hold_full;
   assign w_accept  = sym_valid & ~r_hold_full;
   assign S         = r_S;
   assign s_valid   = r_s_valid;
   assign underrun  = r_underrun;

   // Table is read with the phase the next sample will carry, so outputs can be registered
   assign w_idx_q = w_phase_nx - Q_OFFSET;

   oqpsk_cos_lut #(
      .R (R),
      .N (N)
   ) u_lut (
      .i_idx_i (w_phase_nx),
      .i_idx_q (w_idx_q),
      .o_cos_i (w_cos_i),
      .o_cos_q (w_cos_q)
   );

   // Next-state, counters and rail amplitudes for the symbol sequencer
   always_comb begin
      w_state_nx    = r_state;
      w_cnt_nx      = r_cnt;
      w_phase_nx    = r_phase;
      w_amp_i_nx    = r_amp_i;
      w_amp_q_nx    = r_amp_q;
      w_q_pend_nx   = r_q_pend;
      w_load        = 1'b0;
      w_underrun_nx = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nx   = '0;
            w_phase_nx = '0;
            if (r_hold_full) begin
               w_load      = 1'b1;
               w_amp_i_nx  = bit_to_amp(r_hold_data[1]);
               w_q_pend_nx = r_hold_data[0];
               w_amp_q_nx  = AMP_ZERO;
               w_state_nx  = RUN;
            end
         end
         RUN: begin
            w_phase_nx = r_phase + 1'b1;
            w_cnt_nx   = r_cnt + 1'b1;
            if (r_cnt == CNT_H_END) begin
               w_amp_q_nx = bit_to_amp(r_q_pend);
            end
            if (r_cnt == CNT_SYM_END) begin
               w_cnt_nx = '0;
               if (r_hold_full) begin
                  w_load      = 1'b1;
                  w_amp_i_nx  = bit_to_amp(r_hold_data[1]);
                  w_q_pend_nx = r_hold_data[0];
               end else begin
                  w_amp_i_nx    = AMP_ZERO;
                  w_underrun_nx = 1'b1;
                  w_state_nx    = DRAIN;
               end
            end
         end
         DRAIN: begin
            w_phase_nx = r_phase + 1'b1;
            w_cnt_nx   = r_cnt + 1'b1;
            if (r_cnt == CNT_H_END) begin
               w_state_nx = IDLE;
               w_amp_q_nx = AMP_ZERO;
               w_cnt_nx   = '0;
               w_phase_nx = '0;
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   // Rail samples: amplitude times table value, forced to zero when going idle
   always_comb begin
      w_smp_i = '0;
      w_smp_q = '0;
      if (w_state_nx != IDLE) begin
         case (w_amp_i_nx)
            AMP_POS: w_smp_i = w_cos_i;
            AMP_NEG: w_smp_i = -w_cos_i;
            default: w_smp_i = '0;
         endcase
         case (w_amp_q_nx)
            AMP_POS: w_smp_q = w_cos_q;
            AMP_NEG: w_smp_q = -w_cos_q;
            default: w_smp_q = '0;
         endcase
      end
   end

   // State, hold register and registered outputs
   always_ff @(posedge C) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_hold_full <= 1'b0;
         r_hold_data <= 2'b00;
         r_cnt       <= '0;
         r_phase     <= '0;
         r_amp_i     <= AMP_ZERO;
         r_amp_q     <= AMP_ZERO;
         r_q_pend    <= 1'b0;
         r_S         <= '0;
         r_s_valid   <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_phase    <= w_phase_nx;
         r_amp_i    <= w_amp_i_nx;
         r_amp_q    <= w_amp_q_nx;
         r_q_pend   <= w_q_pend_nx;
         r_S        <= {w_smp_i, w_smp_q};
         r_s_valid  <= (w_state_nx != IDLE);
         r_underrun <= w_underrun_nx;
         if (w_load) begin
            r_hold_full <= 1'b0;
         end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_data <= sym_data;
         end
      end
   end

endmodule

// File: tb/tb_oqpsk_mod_stream.sv
// tb/tb_oqpsk_mod_stream.sv - self-checking bench for oqpsk_mod_stream
module tb_oqpsk_mod_stream;
   localparam int  R   = 7;
   localparam int  N   = 16;
   localparam int  F0  = 10;
   localparam int  SPS = N * F0;
   localparam int  H   = SPS / 2;
   localparam int  A   = (1 << (R - 1)) - 1;
   localparam real PI  = 3.14159265358979;

   logic           C         = 1'b0;
   logic           Reset     = 1'b1;
   logic           sym_valid = 1'b0;
   logic [1:0]     sym_data  = 2'b00;
   logic           sym_ready;
   logic [2*R-1:0] S;
   logic           s_valid;
   logic           underrun;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int tst;
      int off;
      int v;
      int i;
      int q;
      int ur;
   } vec_t;
   vec_t vecs[$];

   logic [1:0] m_syms[$];
   logic [1:0] m_hold[$];
   bit         m_busy = 1'b0;
   int         m_n    = 0;
   int         e_v    = 0;
   int         e_i    = 0;
   int         e_q    = 0;
   int         e_ur   = 0;
   int         e_ready = 1;

   bit dec_i[$];
   bit dec_q[$];
   int dec_k   = 0;
   int ur_seen = 0;

   int cap_v  [0:767];
   int cap_i  [0:767];
   int cap_q  [0:767];
   int cap_ur [0:767];
   logic [1:0] feed[$];
   logic [1:0] sent[$];

   oqpsk_mod_stream #(
      .R  (R),
      .N  (N),
      .F0 (F0)
   ) dut (
      .C         (C),
      .Reset     (Reset),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_ready (sym_ready),
      .S         (S),
      .s_valid   (s_valid),
      .underrun  (underrun)
   );

   always #5 C = ~C;

   function automatic int rnd(input real x);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(-x + 0.5));
   endfunction

   function automatic int ref_cos(input int n);
      return rnd(real'(A) * $cos(2.0 * PI * real'(n % N) / real'(N)));
   endfunction

   function automatic int ref_sin(input int n);
      return rnd(real'(A) * $sin(2.0 * PI * real'(n % N) / real'(N)));
   endfunction

   function automatic int sgn(input logic b);
      return b ? 1 : -1;
   endfunction

   function automatic int dut_i();
      return int'($signed(S[2*R-1:R]));
   endfunction

   function automatic int dut_q();
      return int'($signed(S[R-1:0]));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Burst-level model: sample n of a burst carries symbol n/SPS on I and
   // symbol (n-H)/SPS on Q; the burst ends H samples after the last I symbol.
   task automatic model_step(input logic rst, input logic v, input logic [1:0] d);
      bit acc;
      int ns;
      int s;
      int sq;
      e_ur = 0;
      if (rst) begin
         m_syms.delete();
         m_hold.delete();
         m_busy = 1'b0;
         m_n    = 0;
      end else begin
         acc = v && (m_hold.size() == 0);
         if (!m_busy) begin
            if (m_hold.size() > 0) begin
               m_syms.delete();
               m_syms.push_back(m_hold.pop_front());
               m_busy = 1'b1;
               m_n    = 0;
            end
         end else begin
            if ((m_n == m_syms.size() * SPS - 1) && (m_hold.size() > 0))
               m_syms.push_back(m_hold.pop_front());
            m_n++;
            if (m_n == m_syms.size() * SPS + H) m_busy = 1'b0;
            else if (m_n == m_syms.size() * SPS) e_ur = 1;
         end
         if (acc) m_hold.push_back(d);
      end
      e_v = 0;
      e_i = 0;
      e_q = 0;
      if (m_busy) begin
         ns  = m_syms.size();
         e_v = 1;
         s   = m_n / SPS;
         if (s < ns) e_i = sgn(m_syms[s][1]) * ref_cos(m_n);
         if (m_n >= H) begin
            sq = (m_n - H) / SPS;
            if (sq < ns) e_q = sgn(m_syms[sq][0]) * ref_sin(m_n);
         end
      end
      e_ready = (m_hold.size() == 0) ? 1 : 0;
   endtask

   // Every cycle: advance the model, compare, and decode symbols from the DUT output
   always @(posedge C) begin
      model_step(Reset, sym_valid, sym_data);
      #1;
      chk("cyc_s_valid", int'(s_valid), e_v);
      chk("cyc_sample_i", dut_i(), e_i);
      chk("cyc_sample_q", dut_q(), e_q);
      chk("cyc_underrun", int'(underrun), e_ur);
      chk("cyc_sym_ready", int'(sym_ready), e_ready);
      if (underrun) ur_seen++;
      if (s_valid) begin
         if ((dec_k % SPS == 0) && (dut_i() != 0)) dec_i.push_back(dut_i() > 0);
         if ((dec_k % SPS == H + N / 4) && (dut_q() != 0)) dec_q.push_back(dut_q() > 0);
         dec_k++;
      end else begin
         dec_k = 0;
      end
   end

   task automatic tick();
      @(posedge C);
      #2;
   endtask

   task automatic offer(input logic [1:0] d);
      int guard;
      guard     = 0;
      sym_valid = 1'b1;
      sym_data  = d;
      while (!sym_ready && guard < 1000) begin
         tick();
         guard++;
      end
      chk("offer_ready", int'(sym_ready), 1);
      tick();
      sym_valid = 1'b0;
   endtask

   task automatic capture(input int n);
      bit take;
      for (int k = 0; k < n; k++) begin
         cap_v[k]  = int'(s_valid);
         cap_i[k]  = dut_i();
         cap_q[k]  = dut_q();
         cap_ur[k] = int'(underrun);
         take = 1'b0;
         if (feed.size() > 0) begin
            sym_valid = 1'b1;
            sym_data  = feed[0];
            take      = sym_ready;
         end else begin
            sym_valid = 1'b0;
         end
         tick();
         if (take) void'(feed.pop_front());
      end
      sym_valid = 1'b0;
   endtask

   task automatic check_table(input int t);
      for (int j = 0; j < vecs.size(); j++) begin
         if (vecs[j].tst == t) begin
            chk($sformatf("t%0d_n%0d_valid", t, vecs[j].off), cap_v[vecs[j].off], vecs[j].v);
            chk($sformatf("t%0d_n%0d_i", t, vecs[j].off), cap_i[vecs[j].off], vecs[j].i);
            chk($sformatf("t%0d_n%0d_q", t, vecs[j].off), cap_q[vecs[j].off], vecs[j].q);
            chk($sformatf("t%0d_n%0d_underrun", t, vecs[j].off), cap_ur[vecs[j].off], vecs[j].ur);
         end
      end
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((s_valid || !sym_ready) && guard < 1000) begin
         tick();
         guard++;
      end
      repeat (3) tick();
      chk("wait_idle", int'(s_valid), 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int  idx;
      int  guard;
      int  cnt;
      bit  take;
      bit  dense;

      //                 tst  off  v    I    Q   ur
      vecs.push_back('{2,   0, 1,  63,   0, 0});
      vecs.push_back('{2,   1, 1,  58,   0, 0});
      vecs.push_back('{2,  84, 1,   0,  63, 0});
      vecs.push_back('{2, 159, 1,  58, -24, 0});
      vecs.push_back('{2, 160, 1,   0,   0, 1});
      vecs.push_back('{2, 164, 1,   0,  63, 0});
      vecs.push_back('{2, 239, 1,   0, -24, 0});
      vecs.push_back('{2, 240, 0,   0,   0, 0});
      vecs.push_back('{3,   0, 1,  63,   0, 0});
      vecs.push_back('{3, 160, 1, -63,   0, 0});
      vecs.push_back('{3, 164, 1,   0,  63, 0});
      vecs.push_back('{3, 320, 1,  63,   0, 0});
      vecs.push_back('{3, 404, 1,   0, -63, 0});
      vecs.push_back('{3, 480, 1,   0,   0, 1});
      vecs.push_back('{3, 560, 0,   0,   0, 0});

      // reset held, then idle with no input
      Reset = 1'b1;
      repeat (3) tick();
      chk("rst_S", int'(S), 0);
      chk("rst_s_valid", int'(s_valid), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_sym_ready", int'(sym_ready), 1);
      Reset = 1'b0;
      repeat (5) tick();
      chk("idle_s_valid", int'(s_valid), 0);
      chk("idle_sym_ready", int'(sym_ready), 1);

      // single symbol with drain
      offer(2'b11);
      chk("t2_load_cycle_valid", int'(s_valid), 0);
      tick();
      chk("t2_first_sample_valid", int'(s_valid), 1);
      capture(260);
      check_table(2);
      wait_idle();

      // back-to-back stream
      offer(2'b11);
      feed.push_back(2'b01);
      feed.push_back(2'b10);
      tick();
      capture(600);
      check_table(3);
      wait_idle();

      // continuous sym_valid, scoreboard on decoded symbols
      dec_i.delete();
      dec_q.delete();
      ur_seen = 0;
      for (int j = 0; j < 8; j++) sent.push_back(2'($urandom_range(0, 3)));
      idx   = 0;
      guard = 0;
      while (idx < 8 && guard < 3000) begin
         sym_valid = 1'b1;
         sym_data  = sent[idx];
         take      = sym_ready;
         tick();
         if (take) idx++;
         guard++;
      end
      sym_valid = 1'b0;
      chk("t4_accepted", idx, 8);
      wait_idle();
      chk("t4_underruns", ur_seen, 1);
      chk("t4_dec_i_count", dec_i.size(), 8);
      chk("t4_dec_q_count", dec_q.size(), 8);
      for (int j = 0; j < 8; j++) begin
         if (j < dec_i.size()) chk($sformatf("t4_sym%0d_i", j), int'(dec_i[j]), int'(sent[j][1]));
         if (j < dec_q.size()) chk($sformatf("t4_sym%0d_q", j), int'(dec_q[j]), int'(sent[j][0]));
      end

      // reset mid-run with a symbol held
      offer(2'b11);
      tick();
      repeat (50) tick();
      chk("t5_running", int'(s_valid), 1);
      sym_valid = 1'b1;
      sym_data  = 2'b00;
      tick();
      sym_valid = 1'b0;
      chk("t5_held", int'(sym_ready), 0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("t5_rst_S", int'(S), 0);
      chk("t5_rst_s_valid", int'(s_valid), 0);
      chk("t5_rst_sym_ready", int'(sym_ready), 1);
      repeat (6) tick();
      chk("t5_hold_gone", int'(s_valid), 0);
      offer(2'b01);
      tick();
      chk("t5_restart_i", dut_i(), -63);
      chk("t5_restart_q", dut_q(), 0);
      tick();
      chk("t5_restart_i1", dut_i(), -58);
      wait_idle();

      // symbol offered during drain
      offer(2'b11);
      tick();
      repeat (200) tick();
      chk("t6_drain_i", dut_i(), 0);
      sym_valid = 1'b1;
      sym_data  = 2'b00;
      chk("t6_ready_in_drain", int'(sym_ready), 1);
      tick();
      sym_valid = 1'b0;
      chk("t6_accepted", int'(sym_ready), 0);
      cnt = 0;
      while (s_valid && cnt < 200) begin
         cnt++;
         tick();
      end
      chk("t6_drain_end", 201 + cnt, 240);
      chk("t6_gap_valid", int'(s_valid), 0);
      tick();
      chk("t6_restart_valid", int'(s_valid), 1);
      chk("t6_restart_i", dut_i(), -63);
      chk("t6_restart_q", dut_q(), 0);
      wait_idle();

      // randomized traffic against the model, dense and sparse phases
      for (int c = 0; c < 4000; c++) begin
         dense     = ((c / 500) % 2) == 0;
         sym_valid = dense ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 149) == 0);
         sym_data  = 2'($urandom_range(0, 3));
         Reset     = ($urandom_range(0, 1999) == 0);
         tick();
      end
      Reset     = 1'b0;
      sym_valid = 1'b0;
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
